// File: rtl/ddr3_app_pkg.sv
// rtl/ddr3_app_pkg.sv - shared encodings, widths and state type for the DDR3 app driver
package ddr3_app_pkg;

    localparam int BEAT_BITS      = 256;
    localparam int BEATS_PER_LINE = 2;
    localparam int LINE_BITS      = BEAT_BITS * BEATS_PER_LINE;
    localparam int BEAT_MASK_BITS = BEAT_BITS / 8;
    localparam int LINE_MASK_BITS = LINE_BITS / 8;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

endpackage

// File: rtl/ddr3_app_driver_if.sv
// rtl/ddr3_app_driver_if.sv - client request/response and controller app-side signal bundle
interface ddr3_app_driver_if
    import ddr3_app_pkg::*;
#(
    parameter int ADDR_WIDTH = 27
);

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_WIDTH-4:0]     req_addr;
    logic [LINE_BITS-1:0]      req_data;
    logic [LINE_MASK_BITS-1:0] req_mask;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [LINE_BITS-1:0]      rsp_data;

    logic [2:0]                app_cmd;
    logic                      app_enable;
    logic [ADDR_WIDTH-1:0]     app_addr;
    logic                      app_ready;

    logic                      app_wdf_enable;
    logic [BEAT_BITS-1:0]      app_wdf_data;
    logic [BEAT_MASK_BITS-1:0] app_wdf_mask;
    logic                      app_wdf_end;
    logic                      app_wdf_ready;

    logic                      app_rd_ready;
    logic [BEAT_BITS-1:0]      app_rd_data;

    logic                      err_rd_unexpected;

    modport master (
        input  req_valid, req_write, req_addr, req_data, req_mask, rsp_ready,
               app_ready, app_wdf_ready, app_rd_ready, app_rd_data,
        output req_ready, rsp_valid, rsp_data, app_cmd, app_enable, app_addr,
               app_wdf_enable, app_wdf_data, app_wdf_mask, app_wdf_end,
               err_rd_unexpected
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data, req_mask, rsp_ready,
               app_ready, app_wdf_ready, app_rd_ready, app_rd_data,
        input  req_ready, rsp_valid, rsp_data, app_cmd, app_enable, app_addr,
               app_wdf_enable, app_wdf_data, app_wdf_mask, app_wdf_end,
               err_rd_unexpected
    );

endinterface

// File: rtl/ddr3_rsp_fifo.sv
// rtl/ddr3_rsp_fifo.sv - first-word-fall-through line FIFO holding reassembled read responses
module ddr3_rsp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is not reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign valid    = (count != '0);
    assign pop_data = valid ? mem[rd_ptr] : '0;

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/ddr3_app_driver.sv
// rtl/ddr3_app_driver.sv - splits client line requests into DDR3 app commands/beats and rebuilds read lines
module ddr3_app_driver
    import ddr3_app_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,
    parameter int RD_DEPTH   = 16
) (
    input  logic              user_clock,
    input  logic              user_reset_n,
    input  logic              init_done,
    ddr3_app_driver_if.master bus
);

    localparam int CW = $clog2(RD_DEPTH) + 1;

    state_t state;
    state_t state_nxt;

    logic                      armed;
    logic                      app_enable_q,  app_enable_d;
    logic [2:0]                app_cmd_q,     app_cmd_d;
    logic [ADDR_WIDTH-1:0]     app_addr_q,    app_addr_d;
    logic                      wdf_enable_q,  wdf_enable_d;
    logic [BEAT_BITS-1:0]      wdf_data_q,    wdf_data_d;
    logic [BEAT_MASK_BITS-1:0] wdf_mask_q,    wdf_mask_d;
    logic                      wdf_end_q,     wdf_end_d;
    logic [BEAT_BITS-1:0]      hi_data_q,     hi_data_d;
    logic [BEAT_MASK_BITS-1:0] hi_mask_q,     hi_mask_d;
    logic                      cmd_done_q,    cmd_done_d;
    logic                      data_done_q,   data_done_d;

    logic [CW-1:0]             outstanding;
    logic [CW-1:0]             fifo_count;
    logic [CW:0]               credit_sum;
    logic                      credit_ok;
    logic                      req_ready;
    logic                      accept;
    logic                      cmd_acc;
    logic                      wdf_acc;
    logic                      wr_cmd_fin;
    logic                      wr_data_fin;
    logic                      issue_rd;

    logic                      rd_beat;
    logic [BEAT_BITS-1:0]      beat0_q;
    logic                      beat_ok;
    logic                      push;
    logic                      pop;
    logic                      fifo_valid;
    logic [LINE_BITS-1:0]      fifo_dout;
    logic                      err_q;

    // Reads reserve a FIFO slot up front since read beats cannot be back-pressured.
    assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok  = credit_sum < (CW+1)'(RD_DEPTH);
    assign req_ready  = armed && (state == ST_IDLE) && init_done && (bus.req_write || credit_ok);
    assign accept     = bus.req_valid && req_ready;

    assign cmd_acc     = app_enable_q && bus.app_ready;
    assign wdf_acc     = wdf_enable_q && bus.app_wdf_ready;
    assign wr_cmd_fin  = cmd_done_q || cmd_acc;
    assign wr_data_fin = data_done_q || (wdf_acc && wdf_end_q);
    assign issue_rd    = (state == ST_READ) && cmd_acc;

    always_ff @(posedge user_clock or negedge user_reset_n) begin
        if (!user_reset_n) begin
            armed <= 1'b0;
            state <= ST_IDLE;
        end else begin
            armed <= 1'b1;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = bus.req_write ? ST_WRITE : ST_READ;
            ST_WRITE: if (wr_cmd_fin && wr_data_fin) state_nxt = ST_IDLE;
            ST_READ:  if (cmd_acc) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        app_enable_d = app_enable_q;
        app_cmd_d    = app_cmd_q;
        app_addr_d   = app_addr_q;
        wdf_enable_d = wdf_enable_q;
        wdf_data_d   = wdf_data_q;
        wdf_mask_d   = wdf_mask_q;
        wdf_end_d    = wdf_end_q;
        hi_data_d    = hi_data_q;
        hi_mask_d    = hi_mask_q;
        cmd_done_d   = cmd_done_q;
        data_done_d  = data_done_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    app_enable_d = 1'b1;
                    app_cmd_d    = bus.req_write ? CMD_WRITE : CMD_READ;
                    app_addr_d   = {bus.req_addr, 3'b000};
                    cmd_done_d   = 1'b0;
                    data_done_d  = 1'b0;
                    if (bus.req_write) begin
                        wdf_enable_d = 1'b1;
                        wdf_data_d   = bus.req_data[BEAT_BITS-1:0];
                        wdf_mask_d   = bus.req_mask[BEAT_MASK_BITS-1:0];
                        wdf_end_d    = 1'b0;
                        hi_data_d    = bus.req_data[LINE_BITS-1:BEAT_BITS];
                        hi_mask_d    = bus.req_mask[LINE_MASK_BITS-1:BEAT_MASK_BITS];
                    end
                end
            end
            ST_WRITE: begin
                if (cmd_acc) begin
                    app_enable_d = 1'b0;
                    cmd_done_d   = 1'b1;
                end
                if (wdf_acc) begin
                    if (!wdf_end_q) begin
                        wdf_data_d = hi_data_q;
                        wdf_mask_d = hi_mask_q;
                        wdf_end_d  = 1'b1;
                    end else begin
                        wdf_enable_d = 1'b0;
                        wdf_end_d    = 1'b0;
                        data_done_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (cmd_acc) app_enable_d = 1'b0;
            end
            default: begin
                app_enable_d = 1'b0;
                wdf_enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge user_clock or negedge user_reset_n) begin
        if (!user_reset_n) begin
            app_enable_q <= 1'b0;
            app_cmd_q    <= CMD_WRITE;
            app_addr_q   <= '0;
            wdf_enable_q <= 1'b0;
            wdf_data_q   <= '0;
            wdf_mask_q   <= '0;
            wdf_end_q    <= 1'b0;
            hi_data_q    <= '0;
            hi_mask_q    <= '0;
            cmd_done_q   <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            app_enable_q <= app_enable_d;
            app_cmd_q    <= app_cmd_d;
            app_addr_q   <= app_addr_d;
            wdf_enable_q <= wdf_enable_d;
            wdf_data_q   <= wdf_data_d;
            wdf_mask_q   <= wdf_mask_d;
            wdf_end_q    <= wdf_end_d;
            hi_data_q    <= hi_data_d;
            hi_mask_q    <= hi_mask_d;
            cmd_done_q   <= cmd_done_d;
            data_done_q  <= data_done_d;
        end
    end

    // A beat with nothing outstanding and no half-line pending is a stray and is dropped.
    assign beat_ok = bus.app_rd_ready && (rd_beat || (outstanding != '0));
    assign push    = beat_ok && rd_beat;
    assign pop     = fifo_valid && bus.rsp_ready;

    always_ff @(posedge user_clock or negedge user_reset_n) begin
        if (!user_reset_n) begin
            rd_beat     <= 1'b0;
            beat0_q     <= '0;
            outstanding <= '0;
            err_q       <= 1'b0;
        end else begin
            if (beat_ok) begin
                rd_beat <= ~rd_beat;
                if (!rd_beat) beat0_q <= bus.app_rd_data;
            end
            outstanding <= outstanding + CW'(issue_rd) - CW'(push);
            if (bus.app_rd_ready && !rd_beat && (outstanding == '0)) err_q <= 1'b1;
        end
    end

    ddr3_rsp_fifo #(
        .DEPTH (RD_DEPTH),
        .WIDTH (LINE_BITS)
    ) u_rsp_fifo (
        .clk       (user_clock),
        .rst_n     (user_reset_n),
        .push      (push),
        .push_data ({bus.app_rd_data, beat0_q}),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign bus.req_ready         = req_ready;
    assign bus.rsp_valid         = fifo_valid;
    assign bus.rsp_data          = fifo_dout;
    assign bus.app_cmd           = app_cmd_q;
    assign bus.app_enable        = app_enable_q;
    assign bus.app_addr          = app_addr_q;
    assign bus.app_wdf_enable    = wdf_enable_q;
    assign bus.app_wdf_data      = wdf_data_q;
    assign bus.app_wdf_mask      = wdf_mask_q;
    assign bus.app_wdf_end       = wdf_end_q;
    assign bus.err_rd_unexpected = err_q;

endmodule
